// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state encoding and channel constants for the mux scan controller.
package mux_scan_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;
    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;
    localparam int NUM_CH = 4;
endpackage

// File: rtl/mux_scan_next_ch.sv
// mux_scan_next_ch: finds the lowest enabled channel, either overall (first) or above cur.
module mux_scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [1:0]        cur,
    input  logic              first,
    output logic [1:0]        nxt,
    output logic              found
);
    always_comb begin
        nxt = CH_A;
        found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (mask[i] && (first || 2'(i) > cur)) begin
                nxt = 2'(i);
                found = 1'b1;
            end
    end
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: round-robin scan of a 4:1 mux; settles each enabled channel, captures y_in,
// and publishes the captured word with a one-cycle valid pulse.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               y_in,
    output logic               sel1,
    output logic               sel2,
    output logic               busy,
    output logic [3:0]         sample,
    output logic               sample_valid
);
    state_t state, state_n;
    logic [DWELL_W-1:0] cnt, cnt_n, dwell_q, dwell_n;
    logic [3:0] mask_q, mask_n, acc, acc_n, sample_n;
    logic [1:0] ch, ch_n, nxt;
    logic busy_n, valid_n, found;
    mux_scan_next_ch u_next (
        .mask  (state == IDLE ? mask : mask_q),
        .cur   (ch),
        .first (state == IDLE),
        .nxt   (nxt),
        .found (found)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            dwell_q <= '0;
            mask_q <= '0;
            acc <= '0;
            ch <= CH_A;
            busy <= 1'b0;
            sample <= '0;
            sample_valid <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            dwell_q <= dwell_n;
            mask_q <= mask_n;
            acc <= acc_n;
            ch <= ch_n;
            busy <= busy_n;
            sample <= sample_n;
            sample_valid <= valid_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        dwell_n = dwell_q;
        mask_n = mask_q;
        acc_n = acc;
        ch_n = ch;
        busy_n = busy;
        sample_n = sample;
        valid_n = 1'b0;
        case (state)
            IDLE: if (start) begin
                mask_n = mask;
                dwell_n = dwell;
                acc_n = '0;
                if (found) begin
                    ch_n = nxt;
                    cnt_n = dwell;
                    busy_n = 1'b1;
                    state_n = SETTLE;
                end else begin
                    sample_n = '0;
                    valid_n = 1'b1;
                    state_n = DONE;
                end
            end
            SETTLE: if (cnt == '0) state_n = CAPTURE;
                    else cnt_n = cnt - DWELL_W'(1);
            CAPTURE: begin
                acc_n[ch] = y_in;
                if (found) begin
                    ch_n = nxt;
                    cnt_n = dwell_q;
                    state_n = SETTLE;
                end else begin
                    // park the select on channel a so IDLE always presents 00
                    ch_n = CH_A;
                    sample_n = acc_n;
                    valid_n = 1'b1;
                    busy_n = 1'b0;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    assign sel1 = ch[1];
    assign sel2 = ch[0];
endmodule
